// File: rtl/time_manager_tree_pkg.sv
// Shared time type, +inf sentinel and tree-sizing helpers for the time manager.
package time_manager_tree_pkg;

    typedef logic [31:0] TIME_FORMAT;

    // All-ones is reserved: it is never a real event time and always loses a compare.
    localparam TIME_FORMAT TIME_INF = '1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_nodes(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/time_manager_tree_min_cell.sv
// Two-input min cell returning the smaller key and its channel index; ties keep input a.
// Latency: 1 cycle with REG=1, 0 cycles with REG=0.
// Backpressure: none, every cycle overwrites the output stage.
module time_min_cell
    import time_manager_tree_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  TIME_FORMAT       i_a_key,
    input  logic [IDX_W-1:0] i_a_idx,
    input  TIME_FORMAT       i_b_key,
    input  logic [IDX_W-1:0] i_b_idx,
    input  logic             i_vld,
    output TIME_FORMAT       o_key,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic             w_a_wins;
    TIME_FORMAT       w_key;
    logic [IDX_W-1:0] w_idx;

    assign w_a_wins = (i_a_key <= i_b_key);
    assign w_key    = w_a_wins ? i_a_key : i_b_key;
    assign w_idx    = w_a_wins ? i_a_idx : i_b_idx;

    if (REG) begin : g_reg
        TIME_FORMAT       r_key;
        logic [IDX_W-1:0] r_idx;
        logic             r_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_key <= '0;
                r_idx <= '0;
                r_vld <= 1'b0;
            end else begin
                r_key <= w_key;
                r_idx <= w_idx;
                r_vld <= i_vld;
            end
        end

        assign o_key = r_key;
        assign o_idx = r_idx;
        assign o_vld = r_vld;
    end else begin : g_comb
        logic w_unused_clk;
        assign w_unused_clk = clk ^ rst_n;
        assign o_key = w_key;
        assign o_idx = w_idx;
        assign o_vld = i_vld;
    end

endmodule

// File: rtl/time_manager_tree.sv
// N-channel earliest-event selector with committed global time; TIME_MGR_MONO_CHECK_EN adds sticky mono_err.
// Latency: clog2(N) cycles (1 for N=1) when PIPELINED, else combinational.
// Backpressure: none; advance only gates the commit of time_curr, the tree always flows.
module time_manager_tree
    import time_manager_tree_pkg::*;
#(
    parameter int N         = 4,
    parameter int time_bits = 32,
    parameter bit PIPELINED = 1'b1,
    parameter int IDX_W     = $clog2(N > 1 ? N : 2)
) (
    input  logic                           clk,
    input  logic                           rst,        // active-low, asynchronous
    input  logic [N-1:0][time_bits-1:0]    time_in,
    input  logic [N-1:0]                   in_valid,
    input  logic [N-1:0]                   chan_en,
    input  logic                           advance,
    output logic [time_bits-1:0]           time_next,
    output logic [IDX_W-1:0]               next_idx,
    output logic                           next_valid,
    output logic [time_bits-1:0]           time_curr,
    output logic                           stall,
    output logic                           mono_err
);

    localparam int S = clog2_min1(N);

    logic w_any_en;
    logic w_all_rdy;
    logic w_leaf_vld;

    assign w_any_en   = |chan_en;
    assign w_all_rdy  = &(in_valid | ~chan_en);
    assign w_leaf_vld = w_any_en & w_all_rdy;
    assign stall      = w_any_en & ~w_all_rdy;

    TIME_FORMAT       w_key [S+1][N];
    logic [IDX_W-1:0] w_idx [S+1][N];
    logic             w_vld [S+1][N];

    genvar l, j;
    for (l = 0; l <= S; l++) begin : g_lvl
        for (j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign w_key[l][j] = chan_en[j] ? TIME_FORMAT'(time_in[j]) : TIME_INF;
                assign w_idx[l][j] = IDX_W'(j);
                assign w_vld[l][j] = w_leaf_vld;
            end else if (j < level_nodes(N, l)) begin : g_cell
                TIME_FORMAT       w_b_key;
                logic [IDX_W-1:0] w_b_idx;

                // An unpaired node meets +inf, so it passes through with the same stage delay.
                if ((2 * j + 1) < level_nodes(N, l - 1)) begin : g_pair
                    assign w_b_key = w_key[l-1][2*j+1];
                    assign w_b_idx = w_idx[l-1][2*j+1];
                end else begin : g_odd
                    assign w_b_key = TIME_INF;
                    assign w_b_idx = '0;
                end

                time_min_cell #(
                    .IDX_W (IDX_W),
                    .REG   (PIPELINED)
                ) u_cell (
                    .clk     (clk),
                    .rst_n   (rst),
                    .i_a_key (w_key[l-1][2*j]),
                    .i_a_idx (w_idx[l-1][2*j]),
                    .i_b_key (w_b_key),
                    .i_b_idx (w_b_idx),
                    .i_vld   (w_vld[l-1][2*j]),
                    .o_key   (w_key[l][j]),
                    .o_idx   (w_idx[l][j]),
                    .o_vld   (w_vld[l][j])
                );
            end else begin : g_empty
                assign w_key[l][j] = '0;
                assign w_idx[l][j] = '0;
                assign w_vld[l][j] = 1'b0;
            end
        end
    end

    assign time_next  = w_key[S][0];
    assign next_idx   = w_idx[S][0];
    assign next_valid = w_vld[S][0];

    logic       w_commit;
    TIME_FORMAT r_time_curr;

    assign w_commit = next_valid & advance;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_time_curr <= '0;
        end else if (w_commit) begin
            r_time_curr <= w_key[S][0];
        end
    end

    assign time_curr = r_time_curr;

`ifdef TIME_MGR_MONO_CHECK_EN
    logic r_mono_err;

    // Time still commits when it goes backwards; the flag only records that it happened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mono_err <= 1'b0;
        end else if (w_commit && (w_key[S][0] < r_time_curr)) begin
            r_mono_err <= 1'b1;
        end
    end

    assign mono_err = r_mono_err;
`else
    assign mono_err = 1'b0;
`endif

endmodule

// File: tb/tb_time_manager_tree.sv
// Bench for time_manager_tree: pipelined N=4 instance behind a scoreboard, plus a combinational N=5 instance.
module tb_time_manager_tree;
    import time_manager_tree_pkg::*;

`ifdef TIME_MGR_MONO_CHECK_EN
    localparam logic MONO_EXP = 1'b1;
`else
    localparam logic MONO_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][31:0]  time_in;
    logic [3:0]        in_valid;
    logic [3:0]        chan_en;
    logic              advance;
    logic [31:0]       time_next;
    logic [1:0]        next_idx;
    logic              next_valid;
    logic [31:0]       time_curr;
    logic              stall;
    logic              mono_err;

    logic [4:0][31:0]  c_time_in;
    logic [4:0]        c_valid;
    logic [4:0]        c_en;
    logic              c_adv;
    logic [31:0]       c_next;
    logic [2:0]        c_idx;
    logic              c_nvld;
    logic [31:0]       c_curr;
    logic              c_stall;
    logic              c_mono;

    time_manager_tree #(.N(4), .time_bits(32), .PIPELINED(1'b1)) u_dut (
        .clk(clk), .rst(rst), .time_in(time_in), .in_valid(in_valid), .chan_en(chan_en),
        .advance(advance), .time_next(time_next), .next_idx(next_idx), .next_valid(next_valid),
        .time_curr(time_curr), .stall(stall), .mono_err(mono_err)
    );

    time_manager_tree #(.N(5), .time_bits(32), .PIPELINED(1'b0)) u_comb (
        .clk(clk), .rst(rst), .time_in(c_time_in), .in_valid(c_valid), .chan_en(c_en),
        .advance(c_adv), .time_next(c_next), .next_idx(c_idx), .next_valid(c_nvld),
        .time_curr(c_curr), .stall(c_stall), .mono_err(c_mono)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic [1:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && next_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got valid t=%0d idx=%0d expected no output", time_next, next_idx);
            end else begin
                e = exp_q.pop_front();
                check("sb_time", time_next, e.t);
                check("sb_idx", 32'(next_idx), 32'(e.idx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] vld,
                         input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] t2, input logic [31:0] t3);
        chan_en  = en;
        in_valid = vld;
        time_in[0] = t0;
        time_in[1] = t1;
        time_in[2] = t2;
        time_in[3] = t3;
    endtask

    task automatic idle();
        in_valid = 4'b0000;
        chan_en  = 4'b1111;
    endtask

    task automatic expect_out(input logic [31:0] t, input logic [1:0] idx);
        exp_t e;
        e.t   = t;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Push one sample through to the output and commit it with advance.
    task automatic commit_sample(input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic [31:0] t3,
                                 input logic [31:0] et, input logic [1:0] eidx);
        drive(4'b1111, 4'b1111, t0, t1, t2, t3);
        expect_out(et, eidx);
        tick();
        idle();
        tick();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic comb_vec(input string name, input logic [4:0] en, input logic [4:0] vld,
                            input logic [31:0] et, input logic [2:0] eidx, input logic ev);
        c_en    = en;
        c_valid = vld;
        #1;
        check({name, "_vld"}, 32'(c_nvld), 32'(ev));
        if (ev) begin
            check({name, "_time"}, c_next, et);
            check({name, "_idx"}, 32'(c_idx), 32'(eidx));
        end
    endtask

    initial begin
        rst = 1'b0;
        advance = 1'b0;
        c_adv = 1'b0;
        c_en = '0;
        c_valid = '0;
        c_time_in = '0;
        drive(4'b1111, 4'b1111, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            drive(4'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom);
            advance = 1'($urandom);
            @(negedge clk);
            check("rst_time_next", time_next, 32'd0);
            check("rst_next_idx", 32'(next_idx), 32'd0);
            check("rst_next_valid", 32'(next_valid), 32'd0);
            check("rst_time_curr", time_curr, 32'd0);
            check("rst_mono_err", 32'(mono_err), 32'd0);
        end
        advance = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Min with tie to lower index, and exact two-cycle latency.
        drive(4'b1111, 4'b1111, 32'd40, 32'd15, 32'd27, 32'd15);
        expect_out(32'd15, 2'd1);
        tick();
        idle();
        check("lat_cycle1", 32'(next_valid), 32'd0);
        tick();
        check("lat_cycle2", 32'(next_valid), 32'd1);

        // Masking: channel 1 disabled, then nothing enabled.
        drive(4'b1101, 4'b1111, 32'd40, 32'd15, 32'd27, 32'd15);
        expect_out(32'd15, 2'd3);
        tick();
        drive(4'b0000, 4'b1111, 32'd40, 32'd15, 32'd27, 32'd15);
        #1;
        check("stall_none_en", 32'(stall), 32'd0);
        tick();
        idle();
        repeat (3) tick();

        // Stall on a missing enabled channel, cleared by disabling it.
        drive(4'b1111, 4'b1011, 32'd40, 32'd15, 32'd27, 32'd15);
        #1;
        check("stall_set", 32'(stall), 32'd1);
        tick();
        drive(4'b1011, 4'b1011, 32'd40, 32'd15, 32'd27, 32'd15);
        expect_out(32'd15, 2'd1);
        #1;
        check("stall_clear", 32'(stall), 32'd0);
        tick();
        idle();
        check("stall_no_valid", 32'(next_valid), 32'd0);
        tick();
        check("masked_valid", 32'(next_valid), 32'd1);

        // Back-to-back samples flowing through the pipeline.
        drive(4'b1111, 4'b1111, 32'd5, 32'd5, 32'd5, 32'd5);
        expect_out(32'd5, 2'd0);
        tick();
        drive(4'b1111, 4'b1111, 32'd9, 32'd8, 32'd7, 32'd6);
        expect_out(32'd6, 2'd3);
        tick();
        drive(4'b0100, 4'b0100, 32'd40, 32'd15, 32'd27, 32'd15);
        expect_out(32'd27, 2'd2);
        tick();
        drive(4'b1111, 4'b1111, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        expect_out(32'hFFFF_FFFE, 2'd0);
        tick();
        idle();
        repeat (3) tick();

        // Handshake: valid output without advance leaves time_curr alone.
        drive(4'b1111, 4'b1111, 32'd100, 32'd200, 32'd300, 32'd400);
        expect_out(32'd100, 2'd0);
        tick();
        idle();
        tick();
        check("hold_valid_seen", 32'(next_valid), 32'd1);
        tick();
        check("hold_no_advance", time_curr, 32'd0);

        drive(4'b1111, 4'b1111, 32'd300, 32'd100, 32'd200, 32'd400);
        expect_out(32'd100, 2'd1);
        tick();
        idle();
        tick();
        advance = 1'b1;
        check("commit_before_edge", time_curr, 32'd0);
        tick();
        advance = 1'b0;
        check("commit_100", time_curr, 32'd100);

        // Time going backwards, then forwards again.
        commit_sample(32'd90, 32'd95, 32'd500, 32'd600, 32'd90, 2'd0);
        check("mono_curr_90", time_curr, 32'd90);
        check("mono_err_set", 32'(mono_err), 32'(MONO_EXP));
        commit_sample(32'd700, 32'd95, 32'd500, 32'd600, 32'd95, 2'd1);
        check("mono_curr_95", time_curr, 32'd95);
        check("mono_err_sticky", 32'(mono_err), 32'(MONO_EXP));

        // Reset with a sample in flight: it must be discarded.
        drive(4'b1111, 4'b1111, 32'd7, 32'd8, 32'd9, 32'd10);
        tick();
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(next_valid), 32'd0);
        check("midrst_curr", time_curr, 32'd0);
        check("midrst_mono", 32'(mono_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();

        drive(4'b1111, 4'b1111, 32'd3, 32'd2, 32'd1, 32'd0);
        expect_out(32'd0, 2'd3);
        tick();
        idle();
        check("post_rst_cycle1", 32'(next_valid), 32'd0);
        tick();
        check("post_rst_cycle2", 32'(next_valid), 32'd1);
        repeat (2) tick();

        // Combinational N=5 instance, exercising unpaired nodes at two levels.
        c_time_in[0] = 32'd50;
        c_time_in[1] = 32'd20;
        c_time_in[2] = 32'd30;
        c_time_in[3] = 32'd20;
        c_time_in[4] = 32'd10;
        comb_vec("c_all", 5'b11111, 5'b11111, 32'd10, 3'd4, 1'b1);
        comb_vec("c_mask4", 5'b01111, 5'b01111, 32'd20, 3'd1, 1'b1);
        comb_vec("c_stall", 5'b11111, 5'b01111, 32'd0, 3'd0, 1'b0);
        check("c_stall_flag", 32'(c_stall), 32'd1);
        for (int i = 0; i < 5; i++) c_time_in[i] = 32'd7;
        comb_vec("c_tie", 5'b10100, 5'b10100, 32'd7, 3'd2, 1'b1);
        comb_vec("c_none", 5'b00000, 5'b11111, 32'd0, 3'd0, 1'b0);

        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
